// File: rtl/fm_mod_mc.sv
// fm_mod_mc: multi-channel, 3-stage pipelined FM tuning-word generator,
// out_kc = kc[ch] + ((x * k_max[ch]) >>> (XW-1)). Optional per-channel phase accumulator: FM_PHASE_ACC_EN.
module fm_mod_mc #(
  parameter int W   = 32,
  parameter int XW  = 8,
  parameter int NCH = 4,
  parameter int SAT = 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic          cfg_sel,
  input  logic [W-1:0]  cfg_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [XW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_kc,
  output logic          out_sat
`ifdef FM_PHASE_ACC_EN
  ,
  output logic [W-1:0]  out_phase
`endif
);

  localparam int PW = XW + W + 1;
  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

  // Handshake: a sample moves on a clk edge only when valid && ready are both
  // high at that edge; the output holds while out_valid && !out_ready, and in
  // that case every stage freezes and in_ready drops.
  logic stall;
  logic in_fire;
  assign stall    = out_valid && !out_ready;
  assign in_ready = rst_n && !stall;
  assign in_fire  = in_valid && in_ready;

  logic [W-1:0] kc_bank   [NCH];
  logic [W-1:0] kmax_bank [NCH];

  logic in_ch_ok;
  logic cfg_ch_ok;
  assign in_ch_ok  = ({1'b0, in_ch} < NCH_L);
  assign cfg_ch_ok = ({1'b0, cfg_ch} < NCH_L);

  logic [W-1:0] lk_kc;
  logic [W-1:0] lk_kmax;
  always_comb begin
    lk_kc   = '0;
    lk_kmax = '0;
    if (in_ch_ok) begin
      lk_kc   = kc_bank[in_ch];
      lk_kmax = kmax_bank[in_ch];
    end
  end

  // Stage 1 registers
  logic                 s1_valid;
  logic [CW-1:0]        s1_ch;
  logic [XW-1:0]        s1_x;
  logic [W-1:0]         s1_kc;
  logic [W-1:0]         s1_kmax;

  // Product is sized so that even k_max = 2^W-1 with the most negative x fits.
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shift_c;
  assign x_ext   = {{(W+1){s1_x[XW-1]}}, s1_x};
  assign k_ext   = {{XW{1'b0}}, s1_kmax};
  assign prod    = x_ext * k_ext;
  assign shift_c = prod >>> (XW-1);

  // Stage 2 registers
  logic                 s2_valid;
  logic [CW-1:0]        s2_ch;
  logic [W-1:0]         s2_kc;
  logic signed [PW-1:0] s2_shift;

  logic signed [PW-1:0] sum;
  logic                 sum_neg;
  logic                 sum_big;
  logic [W-1:0]         res_kc;
  logic                 res_sat;
  assign sum     = $signed({{(XW+1){1'b0}}, s2_kc}) + s2_shift;
  assign sum_neg = sum[PW-1];
  assign sum_big = !sum_neg && (|sum[PW-2:W]);

  always_comb begin
    res_kc  = sum[W-1:0];
    res_sat = 1'b0;
    if (SAT != 0 && sum_neg) begin
      res_kc  = '0;
      res_sat = 1'b1;
    end else if (SAT != 0 && sum_big) begin
      res_kc  = '1;
      res_sat = 1'b1;
    end
  end

`ifdef FM_PHASE_ACC_EN
  logic [W-1:0] acc_bank [NCH];
  logic         s2_ch_ok;
  logic [W-1:0] acc_sum;
  assign s2_ch_ok = ({1'b0, s2_ch} < NCH_L);
  always_comb begin
    acc_sum = '0;
    if (s2_ch_ok) acc_sum = acc_bank[s2_ch] + res_kc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) acc_bank[i] <= '0;
      out_phase <= '0;
    end else if (!stall && s2_valid) begin
      if (s2_ch_ok) begin
        acc_bank[s2_ch] <= acc_sum;
        out_phase       <= acc_sum;
      end else begin
        out_phase <= '0;
      end
    end
  end
`else
  // Without the accumulator bank, stage 3 drives only the tuning word.
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        kc_bank[i]   <= '0;
        kmax_bank[i] <= '0;
      end
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_x      <= '0;
      s1_kc     <= '0;
      s1_kmax   <= '0;
      s2_valid  <= 1'b0;
      s2_ch     <= '0;
      s2_kc     <= '0;
      s2_shift  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_kc    <= '0;
      out_sat   <= 1'b0;
    end else begin
      // The lookup above reads the pre-edge bank, so a same-edge sample sees the old value.
      if (cfg_we && cfg_ch_ok) begin
        if (cfg_sel) kmax_bank[cfg_ch] <= cfg_data;
        else         kc_bank[cfg_ch]   <= cfg_data;
      end
      if (!stall) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_ch   <= in_ch;
          s1_x    <= in_x;
          s1_kc   <= lk_kc;
          s1_kmax <= lk_kmax;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_ch    <= s1_ch;
          s2_kc    <= s1_kc;
          s2_shift <= shift_c;
        end
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_ch  <= s2_ch;
          out_kc  <= res_kc;
          out_sat <= res_sat;
        end
      end
    end
  end

endmodule

// File: doc/fm_mod_mc.md
Name: fm_mod_mc

Overview:
Multi-channel, pipelined FM tuning-word generator. For each input sample it computes the frequency word `out_kc = kc[ch] + ((x * k_max[ch]) >>> (XW-1))`.
- `x` is a signed Q1.(XW-1) modulating sample; `kc` is the carrier word and `k_max` the peak deviation word.
- It sits between the modulating-signal source and the per-channel NCO/DDS phase accumulators.
- Channels are time-multiplexed on one datapath, with valid/ready handshake, a selectable saturate/wrap output, and a per-channel config bank.

Parameters:
- W, 32: tuning word width (unsigned Q32.0 at default).
- XW, 8: modulating sample width, signed Q1.(XW-1).
- NCH, 4: number of channels; CW = max(1, $clog2(NCH)).
- SAT, 1: 1 = saturate result to [0, 2^W-1]; 0 = wrap modulo 2^W.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous, active-low reset.
- cfg_we, input, 1: config write strobe.
- cfg_ch, input, CW: config target channel.
- cfg_sel, input, 1: 0 = write kc, 1 = write k_max.
- cfg_data, input, W: config value (unsigned).
- in_valid, input, 1: sample valid.
- in_ready, output, 1: sample accepted when in_valid && in_ready.
- in_ch, input, CW: sample channel.
- in_x, input, XW: signed modulating sample.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_ch, output, CW: result channel.
- out_kc, output, W: modulated tuning word.
- out_sat, output, 1: result was clipped (always 0 when SAT=0).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - kc[] and k_max[] cleared to 0.
  - All stage valids cleared; out_valid=0, out_kc=0, out_ch=0, out_sat=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-stream discards all in-flight samples.
- Config:
  - A write on edge t updates the bank at t.
  - A sample accepted on that same edge t uses the old value; samples accepted later use the new value.
  - Writes with cfg_ch >= NCH are ignored.
  - Config writes are never stalled.
- Pipeline: 3 stages, latency 3 cycles from acceptance edge to out_valid with no backpressure, throughput 1 sample/cycle.
  - S1: register x and ch; look up kc[ch] and k_max[ch]. in_ch >= NCH reads kc = k_max = 0.
  - S2: signed product x * {1'b0, k_max} (XW+W+1 bits), then arithmetic shift right by XW-1, i.e. floor division by 2^(XW-1).
  - S3: sum = kc + shift in W+2-bit signed arithmetic.
    - SAT=1: sum<0 gives 0; sum>2^W-1 gives 2^W-1; out_sat=1 when clipped.
    - SAT=0: out_kc = sum[W-1:0]; out_sat=0.
- Handshake:
  - stall = out_valid && !out_ready; in_ready = !stall (combinational, gated by rst_n).
  - On stall, all stages freeze; out_kc, out_ch and out_sat stay stable.
  - Bubbles propagate with valid=0.
  - No sample is lost, duplicated or reordered.
- Arithmetic boundaries:
  - x = -2^(XW-1) gives shift = -k_max exactly.
  - x = -1, k_max = 1 gives shift = -1 (floor, not truncation toward zero).
  - x = 0 gives out_kc = kc.
  - k_max = 2^W-1 must not overflow the product.
- Simultaneous config write and in-flight sample: the in-flight sample keeps the values latched in S1.

Optional Feature:
Macro FM_PHASE_ACC_EN.
- Defined:
  - Adds output out_phase [W] and a per-channel phase accumulator bank acc[NCH], reset to 0.
  - When S3 loads a valid sample of channel c: new = acc[c] + out_kc (mod 2^W); acc[c] <= new; out_phase <= new.
  - Back-to-back samples of the same channel see the updated acc.
  - out_phase is held during stall.
  - Samples with ch >= NCH do not update any accumulator; out_phase=0 for them.
- Undefined: the out_phase port and accumulator logic are absent; all other behaviour is identical.

Test Plan:
W=32, XW=8, NCH=4, SAT=1 unless stated.
1. Basic: cfg kc[0]=1000, k_max[0]=256; send x=64 on ch0 -> exactly 3 cycles later out_valid=1, out_ch=0, out_kc=1128, out_sat=0; x=-128 -> 744; x=-1, k_max=1 -> 999.
2. Saturation low: kc[1]=100, k_max[1]=256, x=-128 -> out_kc=0, out_sat=1. With SAT=0 -> out_kc=0xFFFFFF64, out_sat=0.
3. Saturation high: kc[2]=0xFFFFFF00, k_max[2]=1024, x=127 -> shift=1016 -> out_kc=0xFFFFFFFF, out_sat=1. k_max=0xFFFFFFFF, kc=0, x=127 -> out_kc=0xFDFFFFFF.
4. Backpressure: stream 6 samples while out_ready=0 for 4 cycles -> in_ready low during stall, outputs stable, all 6 results appear in order with no loss or duplication.
5. Interleave and config race: channels 0,1,2,3 on consecutive cycles with distinct kc -> correct per-channel results; cfg write to kc[0] on the acceptance edge of a ch0 sample -> that sample uses the old kc, the next uses the new. With FM_PHASE_ACC_EN, two ch0 samples with out_kc=1128 -> out_phase=1128 then 2256.
6. Reset mid-stream: assert rst_n=0 with 3 samples in flight -> next cycle out_valid=0, out_kc=0, bank cleared; a subsequent ch0 sample gives out_kc = shift of k_max=0, i.e. 0.
